// File: rtl/mct_arb_pkg.sv
// rtl/mct_arb_pkg.sv - shared encodings for the memory-controller scheduler
package mct_arb_pkg;

    localparam logic [1:0] CU_BYTE = 2'd0;
    localparam logic [1:0] CU_HALF = 2'd1;
    localparam logic [1:0] CU_WORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MM = 1'b1
    } owner_t;

    // The reserved encoding 2 falls through to a full word.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] cu);
        case (cu)
            CU_BYTE: size_to_nbytes = 3'd1;
            CU_HALF: size_to_nbytes = 3'd2;
            default: size_to_nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mct_arb.sv
// rtl/mct_arb.sv - IF/MEM arbiter serialising accesses onto a byte-wide RAM
module mct_arb
    import mct_arb_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_e,
    input  logic [31:0]       if_a,
    output logic              if_ok,
    output logic [31:0]       if_n_o,
    input  logic              mm_mct_e,
    input  logic              mm_mct_wr,
    input  logic [1:0]        mm_mct_cu,
    input  logic [31:0]       mm_mct_a,
    input  logic [31:0]       mm_mct_n_i,
    output logic              mm_mct_ok,
    output logic [31:0]       mm_mct_n_o,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_d_o,
    input  logic [7:0]        ram_d_i
);

    state_t      state, state_d;
    owner_t      owner;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] data;
    logic [31:0] data_cap;
    logic [31:0] addr_cur;
    logic [2:0]  nbytes;
    logic [2:0]  idx;
    logic [1:0]  lane;
    logic        grant;
    logic        grant_mm;
    logic        capture;
    logic        finish_rd;
    logic        unused_addr;

    assign unused_addr = &{1'b0, addr_cur[31:ADDR_W]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        ram_a     = '0;
        ram_wr    = 1'b0;
        ram_d_o   = 8'd0;
        if_ok     = 1'b0;
        mm_mct_ok = 1'b0;
        grant     = 1'b0;
        grant_mm  = 1'b0;
        capture   = 1'b0;
        finish_rd = 1'b0;
        addr_cur  = base + {29'd0, idx};
        // Read data lags its address by one cycle, so it belongs to lane idx-1.
        lane      = idx[1:0] - 2'd1;
        data_cap  = data;
        data_cap[{lane, 3'b000} +: 8] = ram_d_i;

        case (state)
            IDLE: begin
                if (mm_mct_e) begin
                    grant    = 1'b1;
                    grant_mm = 1'b1;
                    state_d  = mm_mct_wr ? WR : RD;
                end else if (if_e) begin
                    grant   = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                if (idx < nbytes) begin
                    ram_a = addr_cur[ADDR_W-1:0];
                end
                if (idx != 3'd0) begin
                    capture = 1'b1;
                end
                if (idx == nbytes) begin
                    finish_rd = 1'b1;
                    state_d   = DONE;
                end
            end
            WR: begin
                ram_wr  = 1'b1;
                ram_a   = addr_cur[ADDR_W-1:0];
                ram_d_o = wdata[{idx[1:0], 3'b000} +: 8];
                if (idx == nbytes - 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (owner == OWN_MM) begin
                    mm_mct_ok = 1'b1;
                end else begin
                    if_ok = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner      <= OWN_IF;
            base       <= 32'd0;
            wdata      <= 32'd0;
            nbytes     <= 3'd0;
            idx        <= 3'd0;
            data       <= 32'd0;
            if_n_o     <= 32'd0;
            mm_mct_n_o <= 32'd0;
        end else begin
            if (grant) begin
                idx  <= 3'd0;
                data <= 32'd0;
                if (grant_mm) begin
                    owner  <= OWN_MM;
                    base   <= mm_mct_a;
                    nbytes <= size_to_nbytes(mm_mct_cu);
                    wdata  <= mm_mct_n_i;
                end else begin
                    owner  <= OWN_IF;
                    base   <= if_a;
                    nbytes <= 3'd4;
                    wdata  <= 32'd0;
                end
            end else if ((state == RD && idx < nbytes) || state == WR) begin
                idx <= idx + 3'd1;
            end

            if (capture) begin
                data <= data_cap;
            end

            // Results are published only on entry to DONE; stores never touch n_o.
            if (finish_rd) begin
                if (owner == OWN_MM) begin
                    mm_mct_n_o <= data_cap;
                end else begin
                    if_n_o <= data_cap;
                end
            end
        end
    end

endmodule

// File: doc/mct_arb.md
Name: mct_arb

Overview:
- Memory-controller scheduler between the CPU pipeline and a byte-wide, single-port RAM.
- Arbitrates two requesters: instruction fetch (IF, read-only, always 4 bytes) and the MEM stage (load/store of 1, 2 or 4 bytes).
- Serialises each access into per-byte RAM cycles and reassembles read data little-endian.
- Returns a one-cycle ok pulse to the requester that owns the completed transaction.

Parameters:
- ADDR_W, 17, width of the RAM address bus; the byte address is truncated to the low ADDR_W bits.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- if_e  in  1  IF request enable
- if_a  in  32  IF byte address
- if_ok  out  1  IF transaction complete, one-cycle pulse
- if_n_o  out  32  IF read data, valid while if_ok=1
- mm_mct_e  in  1  MEM request enable
- mm_mct_wr  in  1  1=store, 0=load
- mm_mct_cu  in  2  access size: 0=byte, 1=half, 3=word, 2=reserved (treated as word)
- mm_mct_a  in  32  MEM byte address
- mm_mct_n_i  in  32  store data, bytes taken from LSB upward
- mm_mct_ok  out  1  MEM transaction complete, one-cycle pulse
- mm_mct_n_o  out  32  load data, zero-extended, valid while mm_mct_ok=1
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_d_o  out  8  RAM write data
- ram_d_i  in  8  RAM read data, valid one cycle after its address is presented

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE and any in-flight transaction is discarded without an ok.
  - All outputs are 0: if_ok, mm_mct_ok, if_n_o, mm_mct_n_o, ram_a, ram_wr, ram_d_o.
- States:
  - IDLE: arbitrate.
  - RD: issue read addresses and capture bytes.
  - WR: issue write bytes.
  - DONE: pulse ok.
- IDLE arbitration:
  - If mm_mct_e=1, MEM wins. Otherwise, if if_e=1, IF wins.
  - MEM has fixed priority; there is no fairness counter.
  - On grant, latch owner, address, n bytes (IF: 4; MEM: 1/2/4 from cu), wr, and store data.
  - Next state is RD or WR; the byte index idx is cleared.
- Inputs are ignored after latching. Changes to a/n_i/cu/e mid-transaction have no effect.
- RD:
  - Each cycle while idx<n: ram_a = (base+idx) truncated to ADDR_W bits, and idx increments.
  - Each cycle after the first: capture ram_d_i into byte lane idx-1 of the data register.
  - When the byte for lane n-1 is captured, go to DONE.
  - Latency: grant at IDLE cycle t, ok at cycle t+n+2 (word read: t+6).
- WR:
  - Each cycle: ram_wr=1, ram_a=(base+idx) truncated, ram_d_o = n_i byte idx.
  - After byte n-1, go to DONE.
  - Latency: grant at t, ok at t+n+1 (word store: t+5).
- DONE:
  - Exactly one cycle. The owner's ok=1 and its n_o holds the assembled data.
  - Unused upper bytes are 0 for byte and half accesses.
  - The non-owner's ok=0. Next state is IDLE.
  - Requester e is not sampled in DONE; the requester must drop e combinationally on ok.
- n_o registers:
  - Update only at the transition into DONE, for the owning requester.
  - Hold value otherwise; no store updates mm_mct_n_o.
- Outside WR: ram_wr=0 and ram_d_o=0. In IDLE and DONE, ram_a=0.
- Address wrap: base+idx is 32-bit modulo, then truncated to ADDR_W. Example: base 0x1FFFF, half, ADDR_W=17 gives addresses 0x1FFFF, 0x00000.
- Simultaneous requests in IDLE: MEM is served first. IF stays pending, is granted at the IDLE after MEM's DONE, and must keep if_e high.
- A requester still holding e high in IDLE after its ok starts a new transaction; this is legal for back-to-back fetches.

Decomposition:
- Shared package holds:
  - Size encodings: CU_BYTE=0, CU_HALF=1, CU_WORD=3.
  - State enum: IDLE, RD, WR, DONE.
  - Owner encoding: OWN_IF, OWN_MM.
  - Function size_to_nbytes(cu).
- Single module; no sub-module is warranted (byte counter and lane assembler are small and inline).

Test Plan:
- Word read: RAM[0x100..0x103]=11,22,33,44, if_e=1, if_a=0x100 -> ram_a 0x100..0x103 on consecutive cycles; if_ok pulse 6 cycles after grant with if_n_o=0x44332211; mm_mct_ok stays 0.
- Byte store: mm_mct_e=1, wr=1, cu=0, a=0x20, n_i=0xDEADBEEF -> single ram_wr cycle with ram_a=0x20, ram_d_o=0xEF; mm_mct_ok at grant+2.
- Collision: if_e and mm_mct_e both rise in the same cycle with a MEM word load -> MEM completes first (ok at t+6); IF granted at t+7; if_ok at t+13.
- Wrap: half load at 0x1FFFF with RAM[0x1FFFF]=0xAB, RAM[0]=0xCD -> ram_a 0x1FFFF, 0x00000; mm_mct_n_o=0x0000CDAB.
- Reset mid-operation: rst=0 during the second byte of a word write -> next cycle all outputs 0, state IDLE, no ok ever issued; subsequent IF read completes normally.
- Mid-transaction change: change mm_mct_a during RD -> the issued addresses still follow the latched base.
